// File: rtl/axis_1553_bc_sequencer.sv
// MIL-STD-1553 bus-controller transfer sequencer: command word, data phase, status wait, one result beat.
// Optional feature macro BC_BROADCAST_EN: RT address 31 is treated as broadcast.
module axis_1553_bc_sequencer #(
  parameter int clock_speed = 100000000,
  parameter int timeout_us  = 40
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [15:0] s_cmd_tdata,
  input  logic        s_cmd_tvalid,
  output logic        s_cmd_tready,
  input  logic [15:0] s_data_tdata,
  input  logic        s_data_tvalid,
  output logic        s_data_tready,
  output logic [15:0] m_enc_tdata,
  output logic [7:0]  m_enc_tuser,
  output logic        m_enc_tvalid,
  input  logic        m_enc_tready,
  input  logic [15:0] s_dec_tdata,
  input  logic [7:0]  s_dec_tuser,
  input  logic        s_dec_tvalid,
  output logic        s_dec_tready,
  output logic [15:0] m_data_tdata,
  output logic        m_data_tvalid,
  input  logic        m_data_tready,
  output logic [15:0] m_res_tdata,
  output logic [3:0]  m_res_tuser,
  output logic        m_res_tvalid,
  input  logic        m_res_tready
);
  localparam int WINDOW = timeout_us * (clock_speed / 1000000);
  localparam int TW     = $clog2(WINDOW + 1);
  localparam logic [TW-1:0] WIN = TW'(WINDOW);

  localparam logic [7:0] SYNC_CMD  = 8'h01;
  localparam logic [7:0] SYNC_DATA = 8'h02;

  localparam logic [3:0] E_OK      = 4'd0;
  localparam logic [3:0] E_NORESP  = 4'd1;
  localparam logic [3:0] E_PARITY  = 4'd2;
  localparam logic [3:0] E_ADDR    = 4'd3;
  localparam logic [3:0] E_SYNC    = 4'd4;
  localparam logic [3:0] E_ILLEGAL = 4'd5;

  typedef enum logic [2:0] {IDLE, TX_CMD, TX_DATA, WAIT_STAT, RX_DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   stat_q, stat_d;
  logic [3:0]    err_q, err_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          bcast;
  logic          unused_tuser;

  assign unused_tuser = ^s_dec_tuser[6:1];

`ifdef BC_BROADCAST_EN
  assign bcast = (cmd_q[15:11] == 5'd31);
`else
  assign bcast = 1'b0;
`endif

  // Subaddress 0/31 is a mode code with no data words; wc=0 encodes 32.
  function automatic logic [5:0] word_count(input logic [15:0] c);
    if (c[9:5] == 5'd0 || c[9:5] == 5'd31) return 6'd0;
    else if (c[4:0] == 5'd0)               return 6'd32;
    else                                   return {1'b0, c[4:0]};
  endfunction

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      stat_q    <= '0;
      err_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      stat_q    <= stat_d;
      err_q     <= err_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    stat_d        = stat_q;
    err_d         = err_q;
    m_enc_tdata   = '0;
    m_enc_tuser   = '0;
    m_enc_tvalid  = 1'b0;
    s_data_tready = 1'b0;
    s_dec_tready  = 1'b1;
    m_data_tdata  = '0;
    m_data_tvalid = 1'b0;
    m_res_tdata   = '0;
    m_res_tuser   = '0;
    m_res_tvalid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_cmd_tvalid && cmd_rdy_q) begin
          cmd_d   = s_cmd_tdata;
          cnt_d   = word_count(s_cmd_tdata);
          stat_d  = '0;
          err_d   = E_OK;
          state_d = TX_CMD;
        end
      end

      TX_CMD: begin
        if (bcast && cmd_q[10]) begin
          // Broadcast transmit request is never put on the bus.
          err_d   = E_ILLEGAL;
          state_d = DONE;
        end else begin
          m_enc_tdata  = cmd_q;
          m_enc_tuser  = SYNC_CMD;
          m_enc_tvalid = 1'b1;
          if (m_enc_tready) begin
            if (!cmd_q[10] && cnt_q != 6'd0) begin
              state_d = TX_DATA;
            end else if (bcast) begin
              state_d = DONE;
            end else begin
              timer_d = WIN;
              state_d = WAIT_STAT;
            end
          end
        end
      end

      TX_DATA: begin
        m_enc_tdata   = s_data_tdata;
        m_enc_tuser   = SYNC_DATA;
        m_enc_tvalid  = s_data_tvalid;
        s_data_tready = m_enc_tready;
        if (s_data_tvalid && m_enc_tready) begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            if (bcast) begin
              state_d = DONE;
            end else begin
              timer_d = WIN;
              state_d = WAIT_STAT;
            end
          end
        end
      end

      WAIT_STAT: begin
        if (s_dec_tvalid) begin
          if (s_dec_tuser[7]) begin
            stat_d = s_dec_tdata;
            if (s_dec_tuser[0]) begin
              err_d   = E_PARITY;
              state_d = DONE;
            end else if (s_dec_tdata[15:11] != cmd_q[15:11]) begin
              err_d   = E_ADDR;
              state_d = DONE;
            end else if (cmd_q[10] && cnt_q != 6'd0) begin
              timer_d = WIN;
              state_d = RX_DATA;
            end else begin
              state_d = DONE;
            end
          end else begin
            err_d   = E_SYNC;
            state_d = DONE;
          end
        end else if (timer_q == '0) begin
          err_d   = E_NORESP;
          state_d = DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      RX_DATA: begin
        s_dec_tready  = m_data_tready;
        m_data_tdata  = s_dec_tdata;
        m_data_tvalid = s_dec_tvalid;
        // A word held back only by the local sink means the RT did answer: no timeout.
        if (s_dec_tvalid) begin
          if (m_data_tready) begin
            cnt_d   = cnt_q - 6'd1;
            timer_d = WIN;
            if (s_dec_tuser[0]) begin
              err_d   = E_PARITY;
              state_d = DONE;
            end else if (s_dec_tuser[7]) begin
              err_d   = E_SYNC;
              state_d = DONE;
            end else if (cnt_q == 6'd1) begin
              state_d = DONE;
            end
          end
        end else if (timer_q == '0) begin
          err_d   = E_NORESP;
          state_d = DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      DONE: begin
        m_res_tdata  = stat_q;
        m_res_tuser  = err_q;
        m_res_tvalid = 1'b1;
        if (m_res_tready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    cmd_rdy_d = (state_d == IDLE);
  end

  assign s_cmd_tready = cmd_rdy_q;

endmodule

// File: tb/tb_axis_1553_bc_sequencer.sv
// Directed bench for axis_1553_bc_sequencer: transfers, error codes, timeout edge, reset.
module tb_axis_1553_bc_sequencer;
  localparam int WIN = 20;

  logic        aclk, arst;
  logic [15:0] s_cmd_tdata;  logic s_cmd_tvalid, s_cmd_tready;
  logic [15:0] s_data_tdata; logic s_data_tvalid, s_data_tready;
  logic [15:0] m_enc_tdata;  logic [7:0] m_enc_tuser; logic m_enc_tvalid, m_enc_tready;
  logic [15:0] s_dec_tdata;  logic [7:0] s_dec_tuser; logic s_dec_tvalid, s_dec_tready;
  logic [15:0] m_data_tdata; logic m_data_tvalid, m_data_tready;
  logic [15:0] m_res_tdata;  logic [3:0] m_res_tuser; logic m_res_tvalid, m_res_tready;

  int checks = 0;
  int errors = 0;

  axis_1553_bc_sequencer #(.clock_speed(1000000), .timeout_us(20)) dut (
    .aclk(aclk), .arst(arst),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
    .m_enc_tdata(m_enc_tdata), .m_enc_tuser(m_enc_tuser), .m_enc_tvalid(m_enc_tvalid),
    .m_enc_tready(m_enc_tready),
    .s_dec_tdata(s_dec_tdata), .s_dec_tuser(s_dec_tuser), .s_dec_tvalid(s_dec_tvalid),
    .s_dec_tready(s_dec_tready),
    .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
    .m_res_tdata(m_res_tdata), .m_res_tuser(m_res_tuser), .m_res_tvalid(m_res_tvalid),
    .m_res_tready(m_res_tready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Hands a command over; returns in the cycle after acceptance.
  task automatic send_cmd(input string tag, input logic [15:0] c, input bit exp_enc);
    int n = 0;
    s_cmd_tdata  = c;
    s_cmd_tvalid = 1'b1;
    while (!s_cmd_tready && n < 50) begin step(); n++; end
    chk({tag, "_cmd_rdy"}, s_cmd_tready, 1);
    step();
    s_cmd_tvalid = 1'b0;
    chk({tag, "_enc_vld"}, m_enc_tvalid, exp_enc);
    if (exp_enc) begin
      chk({tag, "_enc_cmd"}, m_enc_tdata, c);
      chk({tag, "_enc_sync"}, m_enc_tuser, 8'h01);
    end
  endtask

  task automatic send_word(input string tag, input logic [15:0] w);
    s_data_tdata  = w;
    s_data_tvalid = 1'b1;
    #1;
    chk({tag, "_enc_data"}, {m_enc_tvalid, m_enc_tuser, m_enc_tdata}, {1'b1, 8'h02, w});
    step();
    s_data_tvalid = 1'b0;
  endtask

  task automatic dec_word(input logic [15:0] d, input logic [7:0] u);
    s_dec_tdata  = d;
    s_dec_tuser  = u;
    s_dec_tvalid = 1'b1;
    step();
    s_dec_tvalid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [15:0] st, input logic [3:0] code);
    chk({tag, "_res_vld"}, m_res_tvalid, 1);
    chk({tag, "_res_stat"}, m_res_tdata, st);
    chk({tag, "_res_code"}, m_res_tuser, code);
  endtask

  initial begin
    int n, idx, cyc;
    bit hs;
    arst = 1'b1;
    s_cmd_tdata = '0;  s_cmd_tvalid = 0;
    s_data_tdata = '0; s_data_tvalid = 0;
    m_enc_tready = 1;  s_dec_tdata = '0; s_dec_tuser = '0; s_dec_tvalid = 0;
    m_data_tready = 1; m_res_tready = 1;
    #1;
    chk("rst_cmd_rdy", s_cmd_tready, 0);
    chk("rst_dec_rdy", s_dec_tready, 1);
    chk("rst_valids", {m_enc_tvalid, m_data_tvalid, m_res_tvalid, s_data_tready}, 0);
    chk("rst_data", {m_enc_tdata, m_res_tdata}, 0);
    chk("rst_users", {m_enc_tuser, m_res_tuser}, 0);
    step(); step();
    arst = 1'b0;
    chk("rel_cmd_rdy_low", s_cmd_tready, 0);
    step();
    chk("rel_cmd_rdy_high", s_cmd_tready, 1);

    // BC->RT, 3 words with a one-cycle source stall
    send_cmd("bcrt", 16'h0823, 1);
    step();
    chk("bcrt_stall_vld", m_enc_tvalid, 0);
    chk("bcrt_data_rdy", s_data_tready, 1);
    send_word("bcrt_w1", 16'hA1A1);
    send_word("bcrt_w2", 16'hB2B2);
    step();
    chk("bcrt_stall2_vld", m_enc_tvalid, 0);
    send_word("bcrt_w3", 16'hC3C3);
    chk("bcrt_wait_enc", m_enc_tvalid, 0);
    dec_word(16'h0800, 8'h80);
    check_res("bcrt", 16'h0800, 4'd0);
    step();
    chk("bcrt_idle", {m_res_tvalid, s_cmd_tready}, 2'b01);

    // RT->BC, 2 words
    send_cmd("rtbc", 16'h1422, 1);
    step();
    dec_word(16'h1000, 8'h80);
    chk("rtbc_no_res", m_res_tvalid, 0);
    m_data_tready = 0;
    #1;
    chk("rtbc_bp_rdy", s_dec_tready, 0);
    m_data_tready = 1;
    s_dec_tdata = 16'h1234; s_dec_tuser = 8'h00; s_dec_tvalid = 1;
    #1;
    chk("rtbc_d1", {m_data_tvalid, m_data_tdata, s_dec_tready}, {1'b1, 16'h1234, 1'b1});
    step();
    s_dec_tdata = 16'h5678;
    #1;
    chk("rtbc_d2", {m_data_tvalid, m_data_tdata}, {1'b1, 16'h5678});
    step();
    s_dec_tvalid = 0;
    check_res("rtbc", 16'h1000, 4'd0);
    step();

    // No response: result exactly WIN+1 cycles after WAIT_STAT entry
    send_cmd("nresp", 16'h0821, 1);
    step();
    send_word("nresp_w", 16'h5555);
    n = 0;
    while (!m_res_tvalid && n < 100) begin step(); n++; end
    chk("nresp_latency", n, WIN + 1);
    check_res("nresp", 16'h0000, 4'd1);
    step();

    // Address mismatch, then parity taking priority over mismatch (32 data words each)
    send_cmd("badaddr", 16'h0820, 1);
    step();
    for (int i = 0; i < 32; i++) send_word("badaddr_w", 16'h2000 + 16'(i));
    chk("badaddr_wait", m_res_tvalid, 0);
    dec_word(16'h1800, 8'h80);
    check_res("badaddr", 16'h1800, 4'd3);
    step();
    send_cmd("par", 16'h0820, 1);
    step();
    for (int i = 0; i < 32; i++) send_word("par_w", 16'h3000 + 16'(i));
    dec_word(16'h1800, 8'h81);
    check_res("par", 16'h1800, 4'd2);
    step();

    // Mode code, data-sync word where status is expected
    send_cmd("sync", 16'h0800, 1);
    step();
    dec_word(16'h1234, 8'h00);
    check_res("sync", 16'h0000, 4'd4);
    step();

    // Status arriving in the very cycle the timer expires still wins
    send_cmd("edge", 16'h0800, 1);
    step();
    for (int i = 0; i < WIN; i++) step();
    chk("edge_not_yet", m_res_tvalid, 0);
    dec_word(16'h0800, 8'h80);
    check_res("edge", 16'h0800, 4'd0);
    step();

    // RT->BC parity error on a data word: forwarded, then code 2
    send_cmd("rxpar", 16'h1422, 1);
    step();
    dec_word(16'h1000, 8'h80);
    s_dec_tdata = 16'h0BAD; s_dec_tuser = 8'h01; s_dec_tvalid = 1;
    #1;
    chk("rxpar_fwd", {m_data_tvalid, m_data_tdata}, {1'b1, 16'h0BAD});
    step();
    s_dec_tvalid = 0;
    check_res("rxpar", 16'h1000, 4'd2);
    step();

    // wc=0 -> 32 received words under a toggling sink
    send_cmd("rx32", 16'h0C20, 1);
    step();
    dec_word(16'h0800, 8'h80);
    idx = 0; cyc = 0;
    s_dec_tuser = 8'h00; s_dec_tdata = 16'h0100; s_dec_tvalid = 1;
    while (!m_res_tvalid && cyc < 200) begin
      m_data_tready = cyc[0];
      #1;
      hs = m_data_tvalid && m_data_tready;
      if (hs) begin
        chk("rx32_data", m_data_tdata, 16'h0100 + 16'(idx));
        idx++;
      end
      step();
      if (hs) s_dec_tdata = 16'h0100 + 16'(idx);
      if (idx == 32) s_dec_tvalid = 0;
      cyc++;
    end
    m_data_tready = 1;
    chk("rx32_count", idx, 32);
    check_res("rx32", 16'h0800, 4'd0);
    step();

`ifdef BC_BROADCAST_EN
    send_cmd("bcw", 16'hF821, 1);
    step();
    send_word("bcw_w", 16'hDEAD);
    check_res("bcw", 16'h0000, 4'd0);
    step();
    send_cmd("bcr", 16'hFC21, 0);
    step();
    chk("bcr_enc", m_enc_tvalid, 0);
    check_res("bcr", 16'h0000, 4'd5);
    step();
`else
    send_cmd("rt31", 16'hF821, 1);
    step();
    send_word("rt31_w", 16'hDEAD);
    chk("rt31_wait", m_res_tvalid, 0);
    dec_word(16'hF800, 8'h80);
    check_res("rt31", 16'hF800, 4'd0);
    step();
`endif

    // Reset mid-transfer abandons it with no result beat
    send_cmd("mrst", 16'h0823, 1);
    step();
    arst = 1'b1;
    #1;
    chk("mrst_outs", {m_enc_tvalid, s_cmd_tready, s_dec_tready, m_res_tvalid}, 4'b0010);
    step();
    arst = 1'b0;
    step();
    chk("mrst_rdy", {s_cmd_tready, m_res_tvalid}, 2'b10);
    send_cmd("post", 16'h0800, 1);
    step();
    dec_word(16'h0800, 8'h80);
    check_res("post", 16'h0800, 4'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_1553_bc_sequencer.md
# axis_1553_bc_sequencer

MIL-STD-1553 bus-controller transfer sequencer. It takes one command word per request and drives it to the `axis_1553_encoder` input stream. It then handles the word-count-driven data phase, either streaming data out or collecting it from `axis_1553_decoder`, and waits for the RT status word under a no-response timeout. Each transfer ends with a single result beat carrying the status word and an error code.

## Interface
Parameters:
- `clock_speed`, default 100000000: aclk frequency in Hz.
- `timeout_us`, default 40: response window in µs. Window length = timeout_us*(clock_speed/1000000) cycles.

Ports:
- `aclk` in 1: clock, all logic on rising edge.
- `arst` in 1: reset, asynchronous, active-high.
- `s_cmd_tdata` in 16: command word. [15:11] RT address, [10] T/R, [9:5] subaddress, [4:0] word count.
- `s_cmd_tvalid` / `s_cmd_tready` in/out 1: command handshake.
- `s_data_tdata` in 16: BC→RT data words.
- `s_data_tvalid` / `s_data_tready` in/out 1: BC→RT data handshake.
- `m_enc_tdata` out 16: word to the encoder.
- `m_enc_tuser` out 8: sync type. 8'h01 = command/status sync, 8'h02 = data sync.
- `m_enc_tvalid` / `m_enc_tready` out/in 1: encoder handshake.
- `s_dec_tdata` in 16: word from the decoder.
- `s_dec_tuser` in 8: decoder flags. [7] = 1 for command/status sync, 0 for data sync. [0] = parity error.
- `s_dec_tvalid` / `s_dec_tready` in/out 1: decoder handshake.
- `m_data_tdata` out 16: RT→BC data words.
- `m_data_tvalid` / `m_data_tready` out/in 1: RT→BC data handshake.
- `m_res_tdata` out 16: RT status word.
- `m_res_tuser` out 4: error code. 0 OK, 1 no response, 2 parity, 3 RT address mismatch, 4 wrong sync, 5 illegal broadcast.
- `m_res_tvalid` / `m_res_tready` out/in 1: result handshake.

## Operation
- States: IDLE, TX_CMD, TX_DATA, WAIT_STAT, RX_DATA, DONE.
- Word count decoding: N = (wc==0) ? 32 : wc. Subaddress 0 or 31 is a mode code and forces N = 0.
- IDLE
  - s_cmd_tready=1. A command handshake latches the word and goes to TX_CMD.
- TX_CMD
  - Presents the command with tuser 8'h01.
  - On encoder handshake: T/R=0 with N>0 goes to TX_DATA; otherwise goes to WAIT_STAT.
- TX_DATA
  - Combinational pass-through: m_enc_tdata=s_data_tdata, m_enc_tvalid=s_data_tvalid, s_data_tready=m_enc_tready, tuser 8'h02.
  - A 6-bit counter decrements on each handshake. The last word goes to WAIT_STAT.
  - A starved source simply stalls the transfer; there is no error.
- WAIT_STAT
  - The timer loads on entry and decrements each cycle.
  - A decoder word with tuser[7]=1 is the status word. It is checked in priority order: parity (2), then address [15:11] ≠ command RT address (3).
  - A decoder word with tuser[7]=0 gives code 4.
  - Any error, or a good status with T/R=0 or N=0, goes to DONE.
  - A good status with T/R=1 and N>0 reloads the timer and goes to RX_DATA.
  - Timer reaching 0 gives code 1 and goes to DONE.
- RX_DATA
  - Forwards decoder words to m_data. s_dec_tready=m_data_tready.
  - The timer reloads on every word.
  - The counter reaches 0 with no error: go to DONE with code 0.
  - A word with a parity error or tuser[7]=1 is still forwarded, sets code 2 or 4 respectively, and goes to DONE.
  - Timeout gives code 1.
- DONE
  - m_res_tvalid=1 with the latched status word (0 if none was received) and the error code.
  - On handshake, go to IDLE.
- s_dec_tready=1 in every state except RX_DATA. Decoder words arriving in IDLE, TX_CMD, TX_DATA or DONE are discarded.

## Timing
- Reset: state IDLE, counters 0, timer 0, every tvalid and tready output 0 except s_dec_tready=1, all tdata/tuser outputs 0.
- s_cmd_tready is registered and rises the cycle after reset release.
- Command accepted in cycle T: m_enc_tvalid=1 with the command word in T+1 (registered output).
- Status handshake in cycle T: either m_res_tvalid=1 in T+1, or the RX_DATA stream is accepted from T+1.
- Timeout: with no decoder word, code 1 is asserted exactly window+1 cycles after WAIT_STAT entry.
- A decoder word valid in the same cycle the timer expires: the word wins.
- Mid-operation reset: immediate return to IDLE. Partial transfers are abandoned with no result beat.
- Timer width is $clog2(window+1).

## Configuration
- `BC_BROADCAST_EN` defined:
  - RT address 31 is broadcast.
  - T/R=0 broadcast skips WAIT_STAT and completes with status 16'h0000 and code 0 after the last data word.
  - T/R=1 broadcast goes directly from TX_CMD to DONE with code 5. No command is transmitted.
- Undefined: address 31 is treated as an ordinary RT address.

## Test plan
- BC→RT: cmd 16'h0823 (RT1, SA1, 3 words) and data A1A1/B2B2/C3C3, then status 16'h0800 with tuser 8'h80 → encoder sees the 4 words with tuser 01,02,02,02; result {0800, code 0}.
- RT→BC: cmd 16'h1422 (RT2, T, SA1, 2 words), then status 16'h1000 and data 1234/5678 → m_data outputs 1234, 5678; result {1000, code 0}.
- No response: cmd 16'h0821 with the decoder idle → result code 1 exactly window+1 cycles after WAIT_STAT entry; status 0000.
- Bad status: status 16'h1800 (RT3) for cmd 16'h0820 → code 3. Repeating with tuser 8'h81 → code 2.
- Word count 0: cmd 16'h0C20 (T, SA1, wc=0) → 32 data words forwarded, with m_data_tready toggling every cycle; the result is given only after word 32.
- With `BC_BROADCAST_EN`: cmd 16'hF821 → 1 data word sent, result {0000, code 0}. cmd 16'hFC21 → no encoder activity, code 5.
